regwrite_sched: RTL and testbench

REGWRITE_SCHED -- requirements
Module: regwrite_sched

---
 rtl/regwrite_sched.sv | 143 ++++++++++++++
 tb/tb_regwrite_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_sched.sv
// Register-file write scheduler.
// Merges single 32-bit writes and long-multiply lo/hi pair writes onto one
// register-file write port. A pair occupies two consecutive write slots (lo
// then hi). Requests are arbitrated round-robin when both are valid. Reads of
// registers with a write still in flight raise a hazard stall. Writes to r15
// are suppressed and flagged.
module regwrite_sched (
    input  logic        clk,
    input  logic        reset,

    // Single 32-bit write request
    input  logic        req32_valid,
    input  logic [3:0]  req32_addr,
    input  logic [31:0] req32_data,
    output logic        req32_ready,

    // Long-multiply lo/hi pair write request
    input  logic        req64_valid,
    input  logic [3:0]  req64_lo_addr,
    input  logic [3:0]  req64_hi_addr,
    input  logic [31:0] req64_lo_data,
    input  logic [31:0] req64_hi_data,
    output logic        req64_ready,

    // Register-file write port
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,

    // Hazard and status
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    output logic        stall,
    output logic        busy,
    output logic        pc_wr_err
);

    localparam logic [3:0] PcAddr = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StWr32,
        StWrLo,
        StWrHi
    } state_t;

    state_t      state_q;
    logic        rr_q;         // 0: pair wins a tie, 1: single wins a tie
    logic [3:0]  lo_addr_q;
    logic [3:0]  hi_addr_q;
    logic [31:0] hi_data_q;

    logic        accept;
    logic        grant32;
    logic        grant64;
    logic        hit1;
    logic        hit2;

    // Arbitration and handshake; nothing is accepted while reset is held.
    always_comb begin
        accept      = reset && (state_q != StWrLo);
        grant64     = accept && req64_valid && (!req32_valid || !rr_q);
        grant32     = accept && req32_valid && (!req64_valid || rr_q);
        req32_ready = accept && !grant64;
        req64_ready = accept && !grant32;
    end

    // Match read addresses against the destinations still waiting to be written.
    // In WR32 the single-write destination is the registered write address.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        case (state_q)
            StWr32: begin
                hit1 = (ra1 == rf_wa);
                hit2 = (ra2 == rf_wa);
            end
            StWrLo: begin
                hit1 = (ra1 == lo_addr_q) || (ra1 == hi_addr_q);
                hit2 = (ra2 == lo_addr_q) || (ra2 == hi_addr_q);
            end
            StWrHi: begin
                hit1 = (ra1 == hi_addr_q);
                hit2 = (ra2 == hi_addr_q);
            end
            default: begin
                hit1 = 1'b0;
                hit2 = 1'b0;
            end
        endcase
    end

    // Hazard and busy status, forced low while reset is held.
    always_comb begin
        stall = reset && ((hit1 && (ra1 != PcAddr)) || (hit2 && (ra2 != PcAddr)));
        busy  = reset && (state_q != StIdle);
    end

    // Scheduler FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rr_q      <= 1'b0;
            rf_we     <= 1'b0;
            rf_wa     <= 4'h0;
            rf_wd     <= 32'h0;
            pc_wr_err <= 1'b0;
            lo_addr_q <= 4'h0;
            hi_addr_q <= 4'h0;
            hi_data_q <= 32'h0;
        end else if (grant32) begin
            state_q   <= StWr32;
            rr_q      <= 1'b0;
            rf_we     <= (req32_addr != PcAddr);
            rf_wa     <= req32_addr;
            rf_wd     <= req32_data;
            pc_wr_err <= (req32_addr == PcAddr);
        end else if (grant64) begin
            // The lo half is issued straight from the request; the hi half waits.
            state_q   <= StWrLo;
            rr_q      <= 1'b1;
            lo_addr_q <= req64_lo_addr;
            hi_addr_q <= req64_hi_addr;
            hi_data_q <= req64_hi_data;
            rf_we     <= (req64_lo_addr != PcAddr);
            rf_wa     <= req64_lo_addr;
            rf_wd     <= req64_lo_data;
            pc_wr_err <= (req64_lo_addr == PcAddr);
        end else if (state_q == StWrLo) begin
            state_q   <= StWrHi;
            rf_we     <= (hi_addr_q != PcAddr);
            rf_wa     <= hi_addr_q;
            rf_wd     <= hi_data_q;
            pc_wr_err <= (hi_addr_q == PcAddr);
        end else begin
            // No grant: go idle, keep the last address/data on the port.
            state_q   <= StIdle;
            rf_we     <= 1'b0;
            pc_wr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regwrite_sched.sv
// Self-checking bench for regwrite_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// slot-queue model of the write schedule.
module tb_regwrite_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req32_valid;
    logic [3:0]  req32_addr;
    logic [31:0] req32_data;
    logic        req32_ready;
    logic        req64_valid;
    logic [3:0]  req64_lo_addr;
    logic [3:0]  req64_hi_addr;
    logic [31:0] req64_lo_data;
    logic [31:0] req64_hi_data;
    logic        req64_ready;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        stall;
    logic        busy;
    logic        pc_wr_err;

    int checks = 0;
    int passes = 0;

    regwrite_sched dut (
        .clk           (clk),
        .reset         (reset),
        .req32_valid   (req32_valid),
        .req32_addr    (req32_addr),
        .req32_data    (req32_data),
        .req32_ready   (req32_ready),
        .req64_valid   (req64_valid),
        .req64_lo_addr (req64_lo_addr),
        .req64_hi_addr (req64_hi_addr),
        .req64_lo_data (req64_lo_data),
        .req64_hi_data (req64_hi_data),
        .req64_ready   (req64_ready),
        .rf_we         (rf_we),
        .rf_wa         (rf_wa),
        .rf_wd         (rf_wd),
        .ra1           (ra1),
        .ra2           (ra2),
        .stall         (stall),
        .busy          (busy),
        .pc_wr_err     (pc_wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Shadow register file built from the write port.
    logic [31:0] shadow [16];
    always @(posedge clk) begin
        if (reset && rf_we) shadow[rf_wa] <= rf_wd;
    end

    // ---------------- behavioural model ----------------
    // sched holds every write slot not yet completed; sched[0] is the slot on
    // the port this cycle. A new request may enter only when at most the
    // current slot remains.
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } slot_t;

    slot_t       sched [$];
    logic        m_rr;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;

    function automatic logic m_pend(input logic [3:0] ra);
        if (ra == 4'hF) return 1'b0;
        foreach (sched[i]) if (sched[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction

    initial begin : model_cmp
        logic acc, g32, g64;
        logic e_we, e_err;
        logic [3:0] e_wa;
        logic [31:0] e_wd;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sched.delete();
                m_rr = 1'b0;
                m_wa = 4'h0;
                m_wd = 32'h0;
            end
            acc = reset && (sched.size() <= 1);
            g64 = acc && req64_valid && (!req32_valid || !m_rr);
            g32 = acc && req32_valid && (!req64_valid || m_rr);
            if (sched.size() > 0) begin
                e_wa  = sched[0].a;
                e_wd  = sched[0].d;
                e_we  = (sched[0].a != 4'hF);
                e_err = (sched[0].a == 4'hF);
            end else begin
                e_wa  = m_wa;
                e_wd  = m_wd;
                e_we  = 1'b0;
                e_err = 1'b0;
            end
            chk1("m_ready32", req32_ready, acc && !g64);
            chk1("m_ready64", req64_ready, acc && !g32);
            chk1("m_rf_we", rf_we, e_we);
            chk4("m_rf_wa", rf_wa, e_wa);
            chk32("m_rf_wd", rf_wd, e_wd);
            chk1("m_pc_wr_err", pc_wr_err, e_err);
            chk1("m_busy", busy, reset && (sched.size() > 0));
            chk1("m_stall", stall, reset && (m_pend(ra1) || m_pend(ra2)));
            @(posedge clk);
            if (reset) begin
                if (sched.size() > 0) begin
                    m_wa = sched[0].a;
                    m_wd = sched[0].d;
                    void'(sched.pop_front());
                end
                if (g32) begin
                    sched.push_back({req32_addr, req32_data});
                    m_rr = 1'b0;
                end
                if (g64) begin
                    sched.push_back({req64_lo_addr, req64_lo_data});
                    sched.push_back({req64_hi_addr, req64_hi_data});
                    m_rr = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus and literal checks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step_neg();
        cyc();
        @(negedge clk);
    endtask

    task automatic set_pair(input logic [3:0] la, input logic [31:0] ld,
                            input logic [3:0] ha, input logic [31:0] hd);
        req64_valid   = 1'b1;
        req64_lo_addr = la;
        req64_lo_data = ld;
        req64_hi_addr = ha;
        req64_hi_data = hd;
    endtask

    initial begin : main
        int gn;
        int gseq [8];
        int gcyc [8];
        int w32, w64, p32, p64;
        logic h32, h64;

        reset = 1'b0;
        req32_valid = 1'b1;
        req32_addr = 4'h0;
        req32_data = 32'h0;
        req64_valid = 1'b0;
        req64_lo_addr = 4'h0;
        req64_hi_addr = 4'h0;
        req64_lo_data = 32'h0;
        req64_hi_data = 32'h0;
        ra1 = 4'h0;
        ra2 = 4'h0;

        // Reset state
        @(negedge clk);
        chk1("rst_we", rf_we, 1'b0);
        chk4("rst_wa", rf_wa, 4'h0);
        chk32("rst_wd", rf_wd, 32'h0);
        chk1("rst_err", pc_wr_err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready32", req32_ready, 1'b0);
        chk1("rst_stall", stall, 1'b0);

        // Single write accepted in the first cycle after release
        @(posedge clk);
        #2;
        reset = 1'b1;
        req32_addr = 4'h3;
        req32_data = 32'hDEADBEEF;
        @(negedge clk);
        chk1("w32_ready", req32_ready, 1'b1);
        chk1("w32_busy0", busy, 1'b0);
        cyc();
        req32_valid = 1'b0;
        @(negedge clk);
        chk1("w32_we", rf_we, 1'b1);
        chk4("w32_wa", rf_wa, 4'h3);
        chk32("w32_wd", rf_wd, 32'hDEADBEEF);
        chk1("w32_busy1", busy, 1'b1);
        step_neg();
        chk1("w32_we_off", rf_we, 1'b0);
        chk1("w32_busy_off", busy, 1'b0);
        chk4("w32_wa_hold", rf_wa, 4'h3);

        // Pair write with a hazard on the hi destination
        cyc();
        set_pair(4'h2, 32'h1111_1111, 4'h5, 32'h2222_2222);
        ra1 = 4'h5;
        @(negedge clk);
        chk1("p_ready", req64_ready, 1'b1);
        chk1("p_stall0", stall, 1'b0);
        cyc();
        req64_valid = 1'b0;
        @(negedge clk);
        chk1("p_lo_we", rf_we, 1'b1);
        chk4("p_lo_wa", rf_wa, 4'h2);
        chk32("p_lo_wd", rf_wd, 32'h1111_1111);
        chk1("p_stall1", stall, 1'b1);
        step_neg();
        chk1("p_hi_we", rf_we, 1'b1);
        chk4("p_hi_wa", rf_wa, 4'h5);
        chk32("p_hi_wd", rf_wd, 32'h2222_2222);
        chk1("p_stall2", stall, 1'b1);
        step_neg();
        chk1("p_stall3", stall, 1'b0);
        chk1("p_we_off", rf_we, 1'b0);
        ra1 = 4'h0;

        // Pair with hi destination r15
        cyc();
        set_pair(4'h4, 32'hAAAA_AAAA, 4'hF, 32'hBBBB_BBBB);
        cyc();
        req64_valid = 1'b0;
        @(negedge clk);
        chk1("r15_lo_we", rf_we, 1'b1);
        chk4("r15_lo_wa", rf_wa, 4'h4);
        chk1("r15_lo_err", pc_wr_err, 1'b0);
        step_neg();
        chk1("r15_hi_we", rf_we, 1'b0);
        chk1("r15_hi_err", pc_wr_err, 1'b1);
        chk1("r15_hi_busy", busy, 1'b1);
        step_neg();
        chk1("r15_err_off", pc_wr_err, 1'b0);

        // Equal lo/hi destinations: hi data must land last
        cyc();
        set_pair(4'h7, 32'h7777_0001, 4'h7, 32'h7777_0002);
        cyc();
        req64_valid = 1'b0;
        @(negedge clk);
        chk32("eq_lo_wd", rf_wd, 32'h7777_0001);
        step_neg();
        chk32("eq_hi_wd", rf_wd, 32'h7777_0002);
        step_neg();
        chk32("eq_r7_final", shadow[7], 32'h7777_0002);

        // Four back-to-back single writes
        cyc();
        for (int i = 0; i < 4; i++) begin
            req32_valid = 1'b1;
            req32_addr  = 4'(8 + i);
            req32_data  = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
            chk1("st_ready", req32_ready, 1'b1);
            if (i > 0) begin
                chk1("st_we", rf_we, 1'b1);
                chk4("st_wa", rf_wa, 4'(7 + i));
            end
            cyc();
        end
        req32_valid = 1'b0;
        @(negedge clk);
        chk1("st_we_last", rf_we, 1'b1);
        chk4("st_wa_last", rf_wa, 4'hB);
        step_neg();
        chk1("st_we_off", rf_we, 1'b0);

        // Reset asserted while the lo half is on the port
        cyc();
        set_pair(4'h1, 32'h1010_1010, 4'h9, 32'h9090_9090);
        ra1 = 4'h9;
        cyc();
        req64_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk1("rlo_we", rf_we, 1'b0);
        chk1("rlo_busy", busy, 1'b0);
        chk1("rlo_stall", stall, 1'b0);
        chk1("rlo_ready64", req64_ready, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk1("rlo_ready_after", req64_ready, 1'b1);
            chk1("rlo_no_hi", rf_we && (rf_wa == 4'h9), 1'b0);
        end
        ra1 = 4'h0;

        // Continuous contention starting from reset
        cyc();
        reset = 1'b0;
        req32_valid = 1'b1;
        req32_addr = 4'($urandom_range(0, 14));
        req32_data = $urandom;
        set_pair(4'($urandom_range(0, 14)), $urandom, 4'($urandom_range(0, 14)), $urandom);
        @(posedge clk);
        #2;
        reset = 1'b1;
        gn = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            h32 = req32_valid && req32_ready;
            h64 = req64_valid && req64_ready;
            if (gn < 8 && (h32 || h64)) begin
                gseq[gn] = h64 ? 64 : 32;
                gcyc[gn] = c;
                gn++;
            end
            cyc();
            if (h32) begin
                req32_addr = 4'($urandom);
                req32_data = $urandom;
            end
            if (h64) set_pair(4'($urandom), $urandom, 4'($urandom), $urandom);
        end
        chk32("ct_count", 32'(gn), 32'd8);
        chk32("ct_first", 32'(gseq[0]), 32'd64);
        chk32("ct_first_cyc", 32'(gcyc[0]), 32'd0);
        chk32("ct_second", 32'(gseq[1]), 32'd32);
        chk32("ct_second_cyc", 32'(gcyc[1]), 32'd2);
        for (int i = 2; i < 8; i++) chk1("ct_alternate", gseq[i] != gseq[i - 1], 1'b1);
        req32_valid = 1'b0;
        req64_valid = 1'b0;

        // Randomized traffic; requesters hold until accepted
        w32 = 0;
        w64 = 0;
        for (int c = 0; c < 3000; c++) begin
            p32 = (c < 1000) ? 40 : ((c < 2000) ? 95 : 70);
            p64 = (c < 1000) ? 30 : ((c < 2000) ? 90 : 50);
            @(negedge clk);
            h32 = req32_valid && req32_ready;
            h64 = req64_valid && req64_ready;
            if (req32_valid && !req32_ready) w32++;
            if (req64_valid && !req64_ready) w64++;
            if (h32) begin
                chk1("wait32_bound", w32 < 3, 1'b1);
                w32 = 0;
            end
            if (h64) begin
                chk1("wait64_bound", w64 < 3, 1'b1);
                w64 = 0;
            end
            cyc();
            if (!req32_valid || h32) begin
                req32_valid = ($urandom_range(0, 99) < p32);
                req32_addr  = 4'($urandom);
                req32_data  = $urandom;
            end
            if (!req64_valid || h64) begin
                set_pair(4'($urandom), $urandom, 4'($urandom), $urandom);
                req64_valid = ($urandom_range(0, 99) < p64);
            end
            ra1 = 4'($urandom);
            ra2 = 4'($urandom);
        end
        req32_valid = 1'b0;
        req64_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
